// File: rtl/bip_pkg.sv
// Shared definitions for the BIP accumulator CPU control path.
// Opcodes, datapath select encodings, FSM states and decode bundle.
package bip_pkg;

  localparam int NB_INSTR = 16;
  localparam int NB_OPC   = 5;
  localparam int NB_ADDR  = 11;
  localparam int NB_CNT   = 16;

  localparam logic [NB_OPC-1:0] OP_HALT  = 5'd0;
  localparam logic [NB_OPC-1:0] OP_STORE = 5'd1;
  localparam logic [NB_OPC-1:0] OP_LOAD  = 5'd2;
  localparam logic [NB_OPC-1:0] OP_LOADI = 5'd3;
  localparam logic [NB_OPC-1:0] OP_ADD   = 5'd4;
  localparam logic [NB_OPC-1:0] OP_ADDI  = 5'd5;
  localparam logic [NB_OPC-1:0] OP_SUB   = 5'd6;
  localparam logic [NB_OPC-1:0] OP_SUBI  = 5'd7;

  localparam logic [1:0] SEL_A_RAM = 2'b00;
  localparam logic [1:0] SEL_A_IMM = 2'b01;
  localparam logic [1:0] SEL_A_ALU = 2'b10;

  localparam logic SEL_B_RAM = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       alu_op;
    logic       wr_acc;
    logic       wr_ram;
    logic       rd_ram;
    logic       halt;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/bip_decoder.sv
// Opcode to raw control bits; strobes here are ungated.
// Halt and illegal opcodes decode to no strobes at all.
module bip_decoder
  import bip_pkg::*;
#(
  parameter int NB_OPCODE = NB_OPC
) (
  input  logic [NB_OPCODE-1:0] opcode,
  output ctrl_t                ctrl
);

  always_comb begin
    ctrl = '0;
    ctrl.sel_a  = SEL_A_RAM;
    ctrl.sel_b  = SEL_B_RAM;
    ctrl.alu_op = ALU_ADD;
    case (opcode)
      NB_OPCODE'(OP_HALT): begin
        ctrl.halt = 1'b1;
      end
      NB_OPCODE'(OP_STORE): begin
        ctrl.wr_ram = 1'b1;
      end
      NB_OPCODE'(OP_LOAD): begin
        ctrl.rd_ram = 1'b1;
        ctrl.sel_a  = SEL_A_RAM;
        ctrl.wr_acc = 1'b1;
      end
      NB_OPCODE'(OP_LOADI): begin
        ctrl.sel_a  = SEL_A_IMM;
        ctrl.wr_acc = 1'b1;
      end
      NB_OPCODE'(OP_ADD): begin
        ctrl.rd_ram = 1'b1;
        ctrl.sel_b  = SEL_B_RAM;
        ctrl.alu_op = ALU_ADD;
        ctrl.sel_a  = SEL_A_ALU;
        ctrl.wr_acc = 1'b1;
      end
      NB_OPCODE'(OP_ADDI): begin
        ctrl.sel_b  = SEL_B_IMM;
        ctrl.alu_op = ALU_ADD;
        ctrl.sel_a  = SEL_A_ALU;
        ctrl.wr_acc = 1'b1;
      end
      NB_OPCODE'(OP_SUB): begin
        ctrl.rd_ram = 1'b1;
        ctrl.sel_b  = SEL_B_RAM;
        ctrl.alu_op = ALU_SUB;
        ctrl.sel_a  = SEL_A_ALU;
        ctrl.wr_acc = 1'b1;
      end
      NB_OPCODE'(OP_SUBI): begin
        ctrl.sel_b  = SEL_B_IMM;
        ctrl.alu_op = ALU_SUB;
        ctrl.sel_a  = SEL_A_ALU;
        ctrl.wr_acc = 1'b1;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/bip_control_unit.sv
// BIP control unit: PC, IDLE/RUN/HALT sequencing and strobe gating.
// One instruction retires per enabled RUN cycle.
module bip_control_unit
  import bip_pkg::*;
#(
  parameter int NB_INSTRUCTION = NB_INSTR,
  parameter int NB_OPCODE      = NB_OPC,
  parameter int NB_ADDRESS     = NB_ADDR,
  parameter int NB_COUNT       = NB_CNT
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic                      i_enable,
  input  logic [NB_INSTRUCTION-1:0] i_instruction,
  output logic [NB_ADDRESS-1:0]     o_pc,
  output logic [NB_ADDRESS-1:0]     o_operand,
  output logic [1:0]                o_sel_a,
  output logic                      o_sel_b,
  output logic                      o_alu_op,
  output logic                      o_wr_acc,
  output logic                      o_wr_ram,
  output logic                      o_rd_ram,
  output logic                      o_halted,
  output logic                      o_illegal,
  output logic [NB_COUNT-1:0]       o_retired
);

  state_t state;
  ctrl_t  ctrl;
  logic   step;

  bip_decoder #(
    .NB_OPCODE (NB_OPCODE)
  ) u_decoder (
    .opcode (i_instruction[NB_INSTRUCTION-1 -: NB_OPCODE]),
    .ctrl   (ctrl)
  );

  assign step = (state == ST_RUN) && i_enable && !i_reset;

  assign o_operand = i_instruction[NB_ADDRESS-1:0];
  assign o_sel_a   = ctrl.sel_a;
  assign o_sel_b   = ctrl.sel_b;
  assign o_alu_op  = ctrl.alu_op;
  assign o_wr_acc  = step & ctrl.wr_acc;
  assign o_wr_ram  = step & ctrl.wr_ram;
  assign o_rd_ram  = step & ctrl.rd_ram;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      o_pc      <= '0;
      o_retired <= '0;
      o_illegal <= 1'b0;
      o_halted  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (i_start) state <= ST_RUN;
        end
        ST_RUN: begin
          if (i_enable) begin
            if (~&o_retired) o_retired <= o_retired + NB_COUNT'(1);
            if (ctrl.halt) begin
              state    <= ST_HALT;
              o_halted <= 1'b1;
            end else begin
              o_pc <= o_pc + NB_ADDRESS'(1);
            end
            if (ctrl.illegal) o_illegal <= 1'b1;
          end
        end
        ST_HALT: begin
          o_halted <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bip_control_unit.sv
// Directed bench for bip_control_unit, default and narrow-PC configs.
// Program memory is modelled as a negedge-sampled ROM.
module tb_bip_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        start3;
  logic        enable;
  logic [15:0] instr;
  logic [15:0] instr3;

  logic [10:0] pc;
  logic [10:0] operand;
  logic [1:0]  sel_a;
  logic        sel_b;
  logic        alu_op;
  logic        wr_acc;
  logic        wr_ram;
  logic        rd_ram;
  logic        halted;
  logic        illegal;
  logic [15:0] retired;

  logic [2:0]  pc3;
  logic [2:0]  operand3;
  logic [1:0]  sel_a3;
  logic        sel_b3;
  logic        alu_op3;
  logic        wr_acc3;
  logic        wr_ram3;
  logic        rd_ram3;
  logic        halted3;
  logic        illegal3;
  logic [3:0]  retired3;

  logic [15:0] prog [0:2047];
  logic [15:0] prog3 [0:7];

  logic [2:0]  stb;
  int          nvec = 0;
  int          nbad = 0;

  assign stb = {wr_acc, wr_ram, rd_ram};

  always #5 clk = ~clk;

  always @(negedge clk) begin
    instr  <= prog[pc];
    instr3 <= prog3[pc3];
  end

  bip_control_unit dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_start       (start),
    .i_enable      (enable),
    .i_instruction (instr),
    .o_pc          (pc),
    .o_operand     (operand),
    .o_sel_a       (sel_a),
    .o_sel_b       (sel_b),
    .o_alu_op      (alu_op),
    .o_wr_acc      (wr_acc),
    .o_wr_ram      (wr_ram),
    .o_rd_ram      (rd_ram),
    .o_halted      (halted),
    .o_illegal     (illegal),
    .o_retired     (retired)
  );

  bip_control_unit #(
    .NB_ADDRESS (3),
    .NB_COUNT   (4)
  ) dut3 (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_start       (start3),
    .i_enable      (enable),
    .i_instruction (instr3),
    .o_pc          (pc3),
    .o_operand     (operand3),
    .o_sel_a       (sel_a3),
    .o_sel_b       (sel_b3),
    .o_alu_op      (alu_op3),
    .o_wr_acc      (wr_acc3),
    .o_wr_ram      (wr_ram3),
    .o_rd_ram      (rd_ram3),
    .o_halted      (halted3),
    .o_illegal     (illegal3),
    .o_retired     (retired3)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    start  = 1'b0;
    start3 = 1'b0;
    enable = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int en_seq [4] = '{1, 0, 0, 1};
  int pc_seq [4] = '{1, 1, 1, 2};

  initial begin
    for (int i = 0; i < 2048; i++) prog[i] = 16'h0000;
    for (int i = 0; i < 8; i++) prog3[i] = 16'h1801;
    prog[0] = 16'h1805;
    prog[1] = 16'h0800;
    prog[2] = 16'h1806;
    prog[3] = 16'h2000;
    prog[4] = 16'h0000;

    reset  = 1'b1;
    start  = 1'b0;
    start3 = 1'b0;
    enable = 1'b1;
    tick();
    tick();
    check("rst_pc", 32'(pc), 0);
    check("rst_ret", 32'(retired), 0);
    check("rst_ill", 32'(illegal), 0);
    check("rst_halt", 32'(halted), 0);
    check("rst_stb", 32'(stb), 0);

    // IDLE ignores enable: nothing moves until start
    reset = 1'b0;
    tick();
    check("idle_pc", 32'(pc), 0);
    check("idle_stb", 32'(stb), 0);

    start = 1'b1;
    tick();
    check("p0_pc", 32'(pc), 0);
    check("p0_stb", 32'(stb), 3'b100);
    check("p0_sela", 32'(sel_a), 2'b01);
    check("p0_opnd", 32'(operand), 5);
    tick();
    check("p1_pc", 32'(pc), 1);
    check("p1_stb", 32'(stb), 3'b010);
    tick();
    check("p2_pc", 32'(pc), 2);
    check("p2_stb", 32'(stb), 3'b100);
    check("p2_sela", 32'(sel_a), 2'b01);
    check("p2_opnd", 32'(operand), 6);
    tick();
    check("p3_pc", 32'(pc), 3);
    check("p3_stb", 32'(stb), 3'b101);
    check("p3_sela", 32'(sel_a), 2'b10);
    check("p3_op", 32'(alu_op), 0);
    check("p3_selb", 32'(sel_b), 0);
    tick();
    check("p4_pc", 32'(pc), 4);
    check("p4_stb", 32'(stb), 0);
    tick();
    check("h_pc", 32'(pc), 4);
    check("h_halt", 32'(halted), 1);
    check("h_ret", 32'(retired), 5);

    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_stb", 32'(stb), 0);
    end
    check("hold_pc", 32'(pc), 4);
    check("hold_ret", 32'(retired), 5);
    check("hold_halt", 32'(halted), 1);

    reset = 1'b1;
    #1;
    check("rsth_stb", 32'(stb), 0);
    tick();
    check("rsth_pc", 32'(pc), 0);
    check("rsth_ret", 32'(retired), 0);
    check("rsth_halt", 32'(halted), 0);

    for (int i = 0; i < 8; i++) prog[i] = 16'h1801;
    prog[3] = 16'hF800;
    do_reset();
    start  = 1'b1;
    enable = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      enable = en_seq[i][0];
      #1;
      check("en_stb", 32'(stb), en_seq[i] != 0 ? 3'b100 : 3'b000);
      tick();
      check("en_pc", 32'(pc), pc_seq[i]);
    end
    tick();
    check("il3_pc", 32'(pc), 3);
    check("il3_stb", 32'(stb), 0);
    check("il3_ill", 32'(illegal), 0);
    tick();
    check("il4_pc", 32'(pc), 4);
    check("il4_ill", 32'(illegal), 1);
    tick();
    check("il5_pc", 32'(pc), 5);
    check("il5_ill", 32'(illegal), 1);
    check("il5_ret", 32'(retired), 5);

    reset = 1'b1;
    #1;
    check("rstr_stb", 32'(stb), 0);
    tick();
    check("rstr_pc", 32'(pc), 0);
    check("rstr_ret", 32'(retired), 0);
    check("rstr_ill", 32'(illegal), 0);
    check("rstr_halt", 32'(halted), 0);
    tick();
    check("rstr_hold", 32'(pc), 0);

    do_reset();
    start3 = 1'b1;
    enable = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) tick();
    check("w_pc7", 32'(pc3), 7);
    check("w_ret7", 32'(retired3), 7);
    tick();
    check("w_pc0", 32'(pc3), 0);
    check("w_ret8", 32'(retired3), 8);
    for (int i = 0; i < 12; i++) tick();
    check("w_pc4", 32'(pc3), 4);
    check("w_sat", 32'(retired3), 15);
    check("w_main", 32'(pc), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
